if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch front end that produces if_pc/if_inst for the IF/ID pipeline register.
- Owns the PC and drives an SRAM-like instruction port (req / addr_ok / data_ok), with one request outstanding at a time.
- Buffers a returned instruction while the pipeline is stalled.
- Requests stalls while a fetch is in flight, and applies branch and flush redirects.

Parameters:
- RESET_PC, 32'hBFC00000, first fetch address after reset.
- PC_INC, 32'd4, sequential PC increment.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- stall  in  6  pipeline stall vector; stall[1]=1 means IF/ID holds this cycle.
- flush  in  1  exception flush, one-cycle pulse.
- new_pc  in  32  exception/ERET target; valid with flush.
- branch_flag_i  in  1  branch taken, one-cycle pulse from ID.
- branch_target_i  in  32  branch target; valid with branch_flag_i.
- inst_req  out  1  instruction request.
- inst_addr  out  32  request address.
- inst_addr_ok  in  1  address accepted this cycle.
- inst_data_ok  in  1  read data returned this cycle.
- inst_rdata  in  32  returned instruction.
- if_pc  out  32  PC of the delivered instruction.
- if_inst  out  32  delivered instruction; 0 (nop) when none is available.
- stallreq_if  out  1  fetch not ready; stall IF and ID.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; pc=RESET_PC.
  - inst_req=0, inst_addr=RESET_PC.
  - buffer, redirect and discard flags all cleared.
  - if_pc=0, if_inst=0, stallreq_if=0.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE -> REQ on the first clock after rst is released.
- REQ:
  - inst_req=1, inst_addr=pc, held stable until inst_addr_ok=1.
  - On addr_ok -> WAIT.
  - addr_ok and data_ok in the same cycle counts as accept-plus-return; the WAIT rules apply in that cycle.
- WAIT: on inst_data_ok=1 the instruction is "available" this cycle (combinational path to if_inst).
- Delivery rule (available this cycle, discard=0):
  - if_pc=pc, if_inst=inst_rdata (or the buffer in HOLD), stallreq_if=0.
  - If stall[1]=0 it is consumed: pc<=next_pc, state->REQ.
  - If stall[1]=1: store inst_rdata in the buffer, state->HOLD.
- HOLD:
  - Drive the buffer every cycle with stallreq_if=0.
  - When stall[1]=0 it is consumed: pc<=next_pc, state->REQ.
- Not available (REQ, or WAIT without data_ok): if_pc=0, if_inst=0, stallreq_if=1.
- next_pc priority: pending flush target > pending branch target > pc+PC_INC (32-bit wrap, no carry out).
- Redirect capture:
  - branch_flag_i latches branch_target_i into the pending-branch register.
  - flush latches new_pc into the pending-flush register and clears any pending branch.
  - Both pending registers clear when their target is loaded into pc.
- Delay slot: a branch arriving during a fetch takes effect after that fetch (the delay slot) is delivered.
- Flush in HOLD:
  - Buffer dropped; pc<=new_pc; state->REQ next cycle.
  - Nothing is delivered that cycle (if_inst=0).
- Flush in REQ before addr_ok, or in WAIT:
  - discard=1; the request still completes per protocol (address is never changed mid-request).
  - When data_ok arrives the data is dropped: if_inst=0, stallreq_if=1.
  - Then pc<=new_pc, discard=0, state->REQ.
- Flush on the same cycle data_ok arrives: the data is discarded.
- Flush takes precedence over branch in the same cycle.
- A flush received while already discarding overwrites the pending target (last flush wins).
- inst_req is never asserted in WAIT or HOLD; at most one request is outstanding.
- Reset asserted mid-transaction: all state clears immediately. A late data_ok after reset release is ignored (state is IDLE/REQ, not WAIT).

Test Plan:
- Reset release, memory with addr_ok and data_ok one cycle after req, stall=0:
  - First inst_addr=32'hBFC00000.
  - Delivered if_pc sequence BFC00000, BFC00004, BFC00008.
  - stallreq_if=1 in each REQ cycle.
- data_ok with inst_rdata=32'h24010001 while stall[1]=1 for 3 cycles:
  - HOLD drives if_inst=24010001 for 3 cycles with no new inst_req.
  - When the stall drops, next inst_addr=pc+4.
- branch_flag_i=1, target 32'hBFC00100, pulsed during the fetch of BFC00008:
  - BFC00008 is delivered (delay slot).
  - Next inst_addr=BFC00100.
- flush=1, new_pc=32'hBFC00380, pulsed in WAIT:
  - The returned word is dropped (if_inst=0).
  - Next inst_addr=BFC00380.
- flush and branch_flag_i in the same cycle: next fetch address=new_pc; the branch is lost.
- rst=0 pulsed while in WAIT, then data_ok raised after release:
  - Outputs are zero during reset.
  - The stray data is ignored.
  - The fetch restarts at BFC00000.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, drives a single-outstanding SRAM-like
// instruction port, buffers a returned word during IF/ID stalls, and applies redirects.
`timescale 1ns/1ps
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] br_tgt_q, br_tgt_d;
  logic [31:0] fl_tgt_q, fl_tgt_d;
  logic        br_pend_q, br_pend_d;
  logic        discard_q, discard_d;

  logic        returning;
  logic        drop;
  logic        br_now;
  logic [31:0] br_tgt_now;
  logic [31:0] seq_pc;
  logic        unused_stall;

  assign unused_stall = ^{stall[5:2], stall[0]};

  assign inst_req  = (state_q == S_REQ);
  assign inst_addr = pc_q;

  always_comb begin
    // A same-cycle accept-plus-return in REQ behaves like a return in WAIT.
    returning  = inst_data_ok &&
                 ((state_q == S_WAIT) || ((state_q == S_REQ) && inst_addr_ok));
    drop       = discard_q | flush;
    br_now     = branch_flag_i | br_pend_q;
    br_tgt_now = branch_flag_i ? branch_target_i : br_tgt_q;
    seq_pc     = br_now ? br_tgt_now : pc_q + PC_INC;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    br_pend_d = br_pend_q;
    br_tgt_d  = br_tgt_q;
    fl_tgt_d  = fl_tgt_q;
    discard_d = discard_q;

    if (branch_flag_i) begin
      br_pend_d = 1'b1;
      br_tgt_d  = branch_target_i;
    end
    if (flush) begin
      br_pend_d = 1'b0;
      fl_tgt_d  = new_pc;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (flush) pc_d = new_pc;
      end
      S_REQ, S_WAIT: begin
        if (returning) begin
          if (drop) begin
            pc_d      = flush ? new_pc : fl_tgt_q;
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else if (!stall[1]) begin
            pc_d      = seq_pc;
            br_pend_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            buf_d   = inst_rdata;
            state_d = S_HOLD;
          end
        end else begin
          if ((state_q == S_REQ) && inst_addr_ok) state_d = S_WAIT;
          if (flush) discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush) begin
          pc_d    = new_pc;
          buf_d   = '0;
          state_d = S_REQ;
        end else if (!stall[1]) begin
          pc_d      = seq_pc;
          br_pend_d = 1'b0;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if_pc       = '0;
    if_inst     = '0;
    stallreq_if = 1'b0;
    case (state_q)
      S_REQ, S_WAIT: begin
        if (returning && !drop) begin
          if_pc   = pc_q;
          if_inst = inst_rdata;
        end else begin
          stallreq_if = 1'b1;
        end
      end
      S_HOLD: begin
        if (!flush) begin
          if_pc   = pc_q;
          if_inst = buf_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      buf_q     <= '0;
      br_tgt_q  <= '0;
      fl_tgt_q  <= '0;
      br_pend_q <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf_q     <= buf_d;
      br_tgt_q  <= br_tgt_d;
      fl_tgt_q  <= fl_tgt_d;
      br_pend_q <= br_pend_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed test-plan steps followed by a randomized phase, all
// outputs checked each cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  if_fetch #(.RESET_PC(32'hBFC00000), .PC_INC(32'd4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .stallreq_if(stallreq_if)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // memory responder
  bit          rand_mode = 0;
  int          lat = 0;
  bit          mem_busy = 0;
  int          busy_age = 0;
  logic [31:0] mem_addr = '0;
  bit          req_seen = 0;
  bit          force_dok = 0;
  bit          ovr_en = 0;
  logic [31:0] ovr = '0;

  // reference model: one fetch in flight, optional held word, pending redirects
  bit          m_started = 0, m_outst = 0, m_held = 0, m_drop = 0, m_br = 0;
  logic [31:0] m_pc = 32'hBFC00000, m_word = '0, m_drop_tgt = '0, m_br_tgt = '0;

  logic [31:0] acc_q[$];
  logic [31:0] del_q[$];
  logic        last_req, last_stall;
  logic [31:0] last_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13572468;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_outst = 0; m_held = 0; m_drop = 0; m_br = 0;
    m_pc = 32'hBFC00000; m_word = '0; m_drop_tgt = '0; m_br_tgt = '0;
    mem_busy = 0; busy_age = 0; req_seen = 0;
  endtask

  // One clock cycle; entered and left just after a falling edge.
  task automatic tick();
    logic aok, dok, exp_req, ret, drp, bv, nbr;
    logic [31:0] bt, seq, e_pc, e_inst, word;
    logic e_stall;
    #1;
    if (rand_mode) begin
      aok = inst_req && ($urandom_range(2) == 0);
      dok = mem_busy ? ($urandom_range(2) == 0) : (aok && ($urandom_range(4) == 0));
    end else begin
      aok = inst_req && req_seen;
      dok = mem_busy && (busy_age >= lat);
    end
    if (force_dok) dok = 1'b1;
    if (!rst) begin aok = 1'b0; dok = 1'b0; end
    word = ovr_en ? ovr : mem_word(mem_busy ? mem_addr : inst_addr);
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = dok ? word : $urandom;
    #1;
    last_req = inst_req; last_inst = if_inst; last_stall = stallreq_if;

    if (!rst) begin
      chk("rst_req", {31'b0, inst_req}, 32'd0);
      chk("rst_addr", inst_addr, 32'hBFC00000);
      chk("rst_pc", if_pc, 32'd0);
      chk("rst_inst", if_inst, 32'd0);
      chk("rst_stallreq", {31'b0, stallreq_if}, 32'd0);
      model_reset();
    end else begin
      exp_req = m_started && !m_outst && !m_held;
      ret = dok && (m_outst || (exp_req && aok));
      drp = m_drop || flush;
      bv  = branch_flag_i || m_br;
      bt  = branch_flag_i ? branch_target_i : m_br_tgt;
      seq = bv ? bt : m_pc + 32'd4;
      e_pc = '0; e_inst = '0; e_stall = 1'b0;
      if (!m_started) begin
      end else if (m_held) begin
        if (!flush) begin e_pc = m_pc; e_inst = m_word; end
      end else if (ret && !drp) begin
        e_pc = m_pc; e_inst = word;
      end else begin
        e_stall = 1'b1;
      end
      chk("inst_req", {31'b0, inst_req}, {31'b0, exp_req});
      if (exp_req) chk("inst_addr", inst_addr, m_pc);
      chk("if_pc", if_pc, e_pc);
      chk("if_inst", if_inst, e_inst);
      chk("stallreq_if", {31'b0, stallreq_if}, {31'b0, e_stall});

      if (inst_req && aok) acc_q.push_back(inst_addr);
      if (!stallreq_if && if_pc != 32'd0 && !stall[1]) del_q.push_back(if_pc);

      nbr = flush ? 1'b0 : bv;
      if (!m_started) begin
        m_started = 1;
        if (flush) m_pc = new_pc;
      end else if (m_held) begin
        if (flush) begin m_held = 0; m_pc = new_pc; end
        else if (!stall[1]) begin m_held = 0; m_pc = seq; nbr = 0; end
      end else if (ret) begin
        m_outst = 0;
        if (drp) begin m_pc = flush ? new_pc : m_drop_tgt; m_drop = 0; end
        else if (!stall[1]) begin m_pc = seq; nbr = 0; end
        else begin m_held = 1; m_word = word; end
      end else begin
        if (exp_req && aok) m_outst = 1;
        if (flush) begin m_drop = 1; m_drop_tgt = new_pc; end
      end
      m_br = nbr; m_br_tgt = bt;

      if (dok) begin mem_busy = 0; busy_age = 0; end
      else if (aok) begin mem_busy = 1; mem_addr = inst_addr; busy_age = 0; end
      else if (mem_busy) busy_age++;
      req_seen = inst_req && !aok;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_accept(input string tag, input logic [31:0] want);
    int n;
    logic [31:0] got;
    n = acc_q.size();
    for (int i = 0; i < 40 && acc_q.size() == n; i++) tick();
    got = 32'hFFFFFFFF;
    if (acc_q.size() > n) got = acc_q[n];
    chk(tag, got, want);
  endtask

  task automatic run_until_del(input int want);
    for (int i = 0; i < 40 && del_q.size() < want; i++) tick();
    chk("deliver_count", del_q.size(), want);
  endtask

  function automatic logic [31:0] del_at(input int i);
    if (i < del_q.size()) return del_q[i];
    return 32'hFFFFFFFF;
  endfunction

  initial begin
    rst = 1'b0; stall = '0; flush = 1'b0; new_pc = '0;
    branch_flag_i = 1'b0; branch_target_i = '0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    @(negedge clk);
    tick(); tick();

    // sequential fetch after reset release
    rst = 1'b1;
    wait_accept("first_addr", 32'hBFC00000);
    run_until_del(2);
    chk("del_pc0", del_at(0), 32'hBFC00000);
    chk("del_pc1", del_at(1), 32'hBFC00004);

    // branch during the fetch of BFC00008: delay slot delivered first
    branch_flag_i = 1'b1; branch_target_i = 32'hBFC00100;
    tick();
    branch_flag_i = 1'b0;
    run_until_del(3);
    chk("delay_slot", del_at(2), 32'hBFC00008);
    wait_accept("branch_addr", 32'hBFC00100);

    // returned word held across a stall
    stall = 6'b000010; ovr_en = 1'b1; ovr = 32'h24010001;
    tick();
    ovr_en = 1'b0;
    chk("hold_first", last_inst, 32'h24010001);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_inst", last_inst, 32'h24010001);
      chk("hold_no_req", {31'b0, last_req}, 32'd0);
    end
    stall = '0;
    tick();
    wait_accept("after_hold", 32'hBFC00104);

    // flush in WAIT: returned word dropped
    lat = 1;
    flush = 1'b1; new_pc = 32'hBFC00380;
    tick();
    flush = 1'b0;
    tick();
    chk("flush_drop_inst", last_inst, 32'd0);
    chk("flush_drop_stall", {31'b0, last_stall}, 32'd1);
    wait_accept("flush_addr", 32'hBFC00380);

    // flush and branch together on the data_ok cycle: flush wins
    lat = 0;
    flush = 1'b1; new_pc = 32'hBFC00500;
    branch_flag_i = 1'b1; branch_target_i = 32'hBFC00600;
    tick();
    flush = 1'b0; branch_flag_i = 1'b0;
    chk("fb_drop_inst", last_inst, 32'd0);
    wait_accept("fb_addr", 32'hBFC00500);
    run_until_del(del_q.size() + 1);
    chk("fb_del", del_at(del_q.size() - 1), 32'hBFC00500);
    wait_accept("branch_lost", 32'hBFC00504);

    // reset during WAIT, then a stray data_ok
    lat = 3;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    force_dok = 1'b1; ovr_en = 1'b1; ovr = 32'hDEADBEEF;
    tick();
    chk("stray_idle", last_inst, 32'd0);
    tick();
    chk("stray_req", last_inst, 32'd0);
    force_dok = 1'b0; ovr_en = 1'b0; lat = 0;
    wait_accept("restart_addr", 32'hBFC00000);

    // randomized traffic
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      stall = 6'($urandom);
      if ($urandom_range(2) != 0) stall[1] = 1'b0;
      flush = ($urandom_range(31) == 0);
      new_pc = $urandom & 32'hFFFFFFFC;
      branch_flag_i = ($urandom_range(15) == 0);
      branch_target_i = $urandom & 32'hFFFFFFFC;
      rst = ($urandom_range(499) != 0);
      tick();
    end
    rst = 1'b1; stall = '0; flush = 1'b0; branch_flag_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
